otter_csr_intr: RTL

//   Machine-mode CSR file and interrupt gate. It sits directly downstream of the OTTER control-unit FSM and upstream of it on the intr line.
//   - Consumes csr_WE, int_taken and mret_exec from the FSM.
//   - Synchronizes and latches the external interrupt request.
//   - Drives the FSM's intr input.
//   - Supplies mtvec (trap target) and mepc (return target) to the PC mux.

---
 rtl/otter_csr_intr_if.sv | 29 ++
 rtl/otter_csr_intr.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/otter_csr_intr_if.sv
// Bus between the OTTER control FSM / datapath and the machine-mode CSR block.
interface otter_csr_intr_if;
    localparam int unsigned XLEN   = 32;
    localparam int unsigned CSR_AW = 12;

    logic              irq_in;
    logic              csr_WE;
    logic              int_taken;
    logic              mret_exec;
    logic [CSR_AW-1:0] csr_addr;
    logic [XLEN-1:0]   csr_wd;
    logic [XLEN-1:0]   pc;
    logic [XLEN-1:0]   csr_rd;
    logic [XLEN-1:0]   mtvec;
    logic [XLEN-1:0]   mepc;
    logic              intr;

    // FSM / datapath side
    modport master (
        output irq_in, csr_WE, int_taken, mret_exec, csr_addr, csr_wd, pc,
        input  csr_rd, mtvec, mepc, intr
    );

    // CSR block side
    modport slave (
        input  irq_in, csr_WE, int_taken, mret_exec, csr_addr, csr_wd, pc,
        output csr_rd, mtvec, mepc, intr
    );
endinterface

// File: rtl/otter_csr_intr.sv
// Machine-mode CSR file (mstatus/mtvec/mepc/mcause) and external interrupt gate.
module otter_csr_intr #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter bit          IRQ_EDGE    = 1'b1,
    parameter logic [31:0] MCAUSE_EXT  = 32'h8000_000B
) (
    input  logic              clk,
    input  logic              RST,
    otter_csr_intr_if.slave   bus
);
    localparam int unsigned XLEN     = 32;
    localparam int unsigned CSR_AW   = 12;
    localparam int unsigned MIE_BIT  = 3;
    localparam int unsigned MPIE_BIT = 7;

    localparam logic [CSR_AW-1:0] ADDR_MSTATUS = 12'h300;
    localparam logic [CSR_AW-1:0] ADDR_MTVEC   = 12'h305;
    localparam logic [CSR_AW-1:0] ADDR_MEPC    = 12'h341;
    localparam logic [CSR_AW-1:0] ADDR_MCAUSE  = 12'h342;

    // Reject illegal synchronizer depths at elaboration
    if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
        $error("otter_csr_intr: SYNC_STAGES must be 2..4");
    end

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES:0]   valid_q;
    logic                   irq_s;
    logic                   irq_d;
    logic                   rise;
    logic                   pending;
    logic                   mie;
    logic                   mpie;
    logic [XLEN-3:0]        mtvec_q;
    logic [XLEN-1:0]        mepc_q;
    logic [XLEN-1:0]        mcause_q;
    logic [XLEN-1:0]        mstatus_w;
    logic                   wr_mstatus;
    logic                   wr_mtvec;
    logic                   wr_mepc;
    logic                   wr_mcause;

    assign irq_s = sync_q[SYNC_STAGES-1];

    // A rise only counts once the previous synchronized sample is a real
    // post-reset observation, so a request held high across reset is ignored.
    assign rise = irq_s & ~irq_d & valid_q[SYNC_STAGES];

    // CSR write decode
    always_comb begin
        wr_mstatus = 1'b0;
        wr_mtvec   = 1'b0;
        wr_mepc    = 1'b0;
        wr_mcause  = 1'b0;
        if (bus.csr_WE) begin
            case (bus.csr_addr)
                ADDR_MSTATUS: wr_mstatus = 1'b1;
                ADDR_MTVEC:   wr_mtvec   = 1'b1;
                ADDR_MEPC:    wr_mepc    = 1'b1;
                ADDR_MCAUSE:  wr_mcause  = 1'b1;
                default:      ;
            endcase
        end
    end

    // Synchronizer chain, post-reset sample-valid tracker and edge history
    always_ff @(posedge clk) begin
        if (RST) begin
            sync_q  <= '0;
            valid_q <= '0;
            irq_d   <= 1'b0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], bus.irq_in};
            valid_q <= {valid_q[SYNC_STAGES-1:0], 1'b1};
            irq_d   <= irq_s;
        end
    end

    // Pending request; a new request beats a same-cycle int_taken clear
    always_ff @(posedge clk) begin
        if (RST) begin
            pending <= 1'b0;
        end else if (IRQ_EDGE) begin
            pending <= rise | (pending & ~bus.int_taken);
        end else begin
            pending <= irq_s;
        end
    end

    // mstatus MIE/MPIE: trap entry > mret > CSR write
    always_ff @(posedge clk) begin
        if (RST) begin
            mie  <= 1'b0;
            mpie <= 1'b0;
        end else if (bus.int_taken) begin
            mpie <= mie;
            mie  <= 1'b0;
        end else if (bus.mret_exec) begin
            mie  <= mpie;
            mpie <= 1'b1;
        end else if (wr_mstatus) begin
            mie  <= bus.csr_wd[MIE_BIT];
            mpie <= bus.csr_wd[MPIE_BIT];
        end
    end

    // mtvec is only touched by CSR writes; low two bits are hardwired zero
    always_ff @(posedge clk) begin
        if (RST) begin
            mtvec_q <= '0;
        end else if (wr_mtvec) begin
            mtvec_q <= bus.csr_wd[XLEN-1:2];
        end
    end

    // mepc/mcause: trap entry overrides a coincident CSR write
    always_ff @(posedge clk) begin
        if (RST) begin
            mepc_q   <= '0;
            mcause_q <= '0;
        end else if (bus.int_taken) begin
            mepc_q   <= bus.pc;
            mcause_q <= MCAUSE_EXT;
        end else begin
            if (wr_mepc) begin
                mepc_q <= {bus.csr_wd[XLEN-1:2], 2'b00};
            end
            if (wr_mcause) begin
                mcause_q <= bus.csr_wd;
            end
        end
    end

    // Architectural mstatus view: only MIE and MPIE are implemented
    always_comb begin
        mstatus_w           = '0;
        mstatus_w[MIE_BIT]  = mie;
        mstatus_w[MPIE_BIT] = mpie;
    end

    // Combinational CSR read returns the pre-write value (CSRRW swap)
    always_comb begin
        bus.csr_rd = '0;
        case (bus.csr_addr)
            ADDR_MSTATUS: bus.csr_rd = mstatus_w;
            ADDR_MTVEC:   bus.csr_rd = {mtvec_q, 2'b00};
            ADDR_MEPC:    bus.csr_rd = mepc_q;
            ADDR_MCAUSE:  bus.csr_rd = mcause_q;
            default:      bus.csr_rd = '0;
        endcase
    end

    assign bus.mtvec = {mtvec_q, 2'b00};
    assign bus.mepc  = mepc_q;
    assign bus.intr  = pending & mie;

endmodule
